// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a small input FIFO.
// Frames are sent back-to-back while the FIFO holds data; tx is registered and idles high.
module uart_tx_cfg #(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 tx_load,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_idle,
    output logic                 tx_overflow,
    output logic                 tx
);

    localparam int DIVIDER = CLOCK_RATE / BAUD;
    localparam int TW      = $clog2(DIVIDER);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int SW      = $clog2(STOP_BITS + 1);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    localparam logic [TW-1:0] RELOAD    = TW'(DIVIDER - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    if (DIVIDER < 2) begin : g_bad_divider
        $error("uart_tx_cfg: CLOCK_RATE / BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5 to 9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_idx;
    logic [SW-1:0]        stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] head;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic bit_end;
    logic last_stop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign push      = tx_load && !full;
    assign tx_ready  = !full;
    assign head      = mem[rd_ptr];
    assign bit_end   = (timer == '0);
    assign last_stop = (state == STOP) && bit_end && (stop_cnt == LAST_STOP);
    // The FIFO is popped either from IDLE or straight out of the final stop bit.
    assign pop       = !empty && ((state == IDLE) || last_stop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            tx_overflow <= tx_load && full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // tx and tx_idle are decoded from the state of the previous cycle, so tx lags the FSM by one clock.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_idle  <= 1'b1;
        end else begin
            tx_idle <= (state == IDLE) && empty;

            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shreg[0];
                PAR:     tx <= par_bit;
                default: tx <= 1'b1;
            endcase

            if (!bit_end) begin
                timer <= timer - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= head;
                        par_bit <= (PARITY == 1) ? ~(^head) : (^head);
                        timer   <= RELOAD;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        timer   <= RELOAD;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        timer <= RELOAD;
                        if (bit_idx == LAST_BIT) begin
                            stop_cnt <= '0;
                            state    <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        stop_cnt <= '0;
                        timer    <= RELOAD;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= RELOAD;
                        if (stop_cnt != LAST_STOP) begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end else if (pop) begin
                            shreg   <= head;
                            par_bit <= (PARITY == 1) ? ~(^head) : (^head);
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: four configurations (8N1, 8E2, 8O1, 7N1) at DIVIDER = 4,
// each checked every cycle against a frame-level model, plus directed literal checks.
module tb_uart_tx_cfg;

    localparam int NI = 4;
    localparam int CFG_DB  [NI] = '{8, 8, 8, 7};
    localparam int CFG_PAR [NI] = '{0, 2, 1, 0};
    localparam int CFG_SB  [NI] = '{1, 2, 1, 1};
    localparam int DEPTH = 4;
    localparam int DIV   = 4;

    logic          clk = 1'b0;
    logic [NI-1:0] nrst;
    logic [NI-1:0] load;
    logic [8:0]    data [NI];
    logic [NI-1:0] txs;
    logic [NI-1:0] rdy;
    logic [NI-1:0] idl;
    logic [NI-1:0] ovf;

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;
    int falls    = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s inst=%0d t=%0t actual=%0h required=%0h", name, inst, $time, act, exp);
        end
    endtask

    // Frame-level reference: a word queue plus the per-cycle line level of the frame in flight.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DB  = CFG_DB[g];
        localparam int PM  = CFG_PAR[g];
        localparam int SB  = CFG_SB[g];
        localparam int LEN = DIV * (1 + DB + ((PM != 0) ? 1 : 0) + SB);

        uart_tx_cfg #(
            .CLOCK_RATE(40), .BAUD(10), .DATA_BITS(DB), .PARITY(PM),
            .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
        ) dut (
            .clk(clk), .nrst(nrst[g]), .tx_load(load[g]), .tx_data(data[g][DB-1:0]),
            .tx_ready(rdy[g]), .tx_idle(idl[g]), .tx_overflow(ovf[g]), .tx(txs[g])
        );

        logic [8:0] q [$];
        bit         line [$];
        int         frameRemain = 0;
        bit         curBit = 1'b1;
        bit         full;
        logic [8:0] w;
        bit expTx = 1'b1, expRdy = 1'b1, expIdle = 1'b1, expOvf = 1'b0;

        function automatic void pushFrame(input logic [8:0] word);
            bit p;
            p = 1'b0;
            for (int i = 0; i < DB; i++) p = p ^ word[i];
            if (PM == 1) p = ~p;
            repeat (DIV) line.push_back(1'b0);
            for (int i = 0; i < DB; i++) repeat (DIV) line.push_back(word[i]);
            if (PM != 0) repeat (DIV) line.push_back(p);
            repeat (DIV * SB) line.push_back(1'b1);
        endfunction

        always @(posedge clk or negedge nrst[g]) begin
            if (!nrst[g]) begin
                q.delete();
                line.delete();
                frameRemain = 0;
                curBit  = 1'b1;
                expTx   = 1'b1;
                expRdy  = 1'b1;
                expIdle = 1'b1;
                expOvf  = 1'b0;
            end else begin
                full    = (q.size() == DEPTH);
                expTx   = curBit;
                expIdle = (q.size() == 0) && (frameRemain == 0);
                if (frameRemain > 0) frameRemain--;
                if (frameRemain == 0 && q.size() > 0) begin
                    w = q.pop_front();
                    pushFrame(w);
                    frameRemain = LEN;
                end
                expOvf = 1'b0;
                if (load[g]) begin
                    if (full) expOvf = 1'b1;
                    else q.push_back(data[g]);
                end
                expRdy = (q.size() != DEPTH);
                curBit = (line.size() > 0) ? line.pop_front() : 1'b1;
            end
        end

        always @(negedge clk) begin
            if (checkEn) begin
                checkOutput("cmp_tx", g, txs[g], expTx);
                checkOutput("cmp_ready", g, rdy[g], expRdy);
                checkOutput("cmp_idle", g, idl[g], expIdle);
                checkOutput("cmp_overflow", g, ovf[g], expOvf);
            end
        end
    end

    task tick();
        @(posedge clk);
        #2;
    endtask

    task automatic tickCount(input int i);
        logic prev;
        prev = txs[i];
        tick();
        if (prev && !txs[i]) falls++;
    endtask

    task automatic applyStimulus(input int i, input logic [8:0] word);
        load[i] = 1'b1;
        data[i] = word;
        tick();
        load[i] = 1'b0;
    endtask

    // Push one word from idle and compare the line against a hand-computed bit-group pattern.
    task automatic checkFrame(input int i, input logic [8:0] word, input logic [15:0] pat,
                              input int groups, input string name);
        applyStimulus(i, word);
        tick();
        checkOutput({name, "_idle_fall"}, i, idl[i], 1'b0);
        checkOutput({name, "_pre_start"}, i, txs[i], 1'b1);
        for (int k = 0; k < 4 * groups; k++) begin
            tick();
            checkOutput({name, "_bit"}, i, txs[i], pat[k/4]);
        end
        checkOutput({name, "_idle_last"}, i, idl[i], 1'b0);
        tick();
        checkOutput({name, "_idle_rise"}, i, idl[i], 1'b1);
        checkOutput({name, "_tx_end"}, i, txs[i], 1'b1);
    endtask

    task automatic waitIdle(input int i, input int budget, input string name);
        for (int t = 0; t < budget && !idl[i]; t++) tick();
        checkOutput(name, i, idl[i], 1'b1);
    endtask

    initial begin
        int density;
        int lows;
        nrst = '1;
        load = '0;
        for (int i = 0; i < NI; i++) data[i] = '0;
        #1 nrst = '0;
        repeat (3) tick();
        nrst = '1;
        checkEn = 1'b1;
        for (int i = 0; i < NI; i++) begin
            checkOutput("reset_tx", i, txs[i], 1'b1);
            checkOutput("reset_ready", i, rdy[i], 1'b1);
            checkOutput("reset_idle", i, idl[i], 1'b1);
            checkOutput("reset_overflow", i, ovf[i], 1'b0);
        end

        checkFrame(0, 9'h055, 16'b1010101010, 10, "f8n1");
        checkFrame(1, 9'h0A3, 16'b110101000110, 12, "f8e2");
        checkFrame(2, 9'h0A3, 16'b11101000110, 11, "f8o1");
        checkFrame(3, 9'h07F, 16'b111111110, 9, "f7n1");

        // Back-to-back: frame starts exactly 40 cycles apart with no extra high cycles.
        applyStimulus(0, 9'h001);
        applyStimulus(0, 9'h002);
        applyStimulus(0, 9'h003);
        for (int t = 0; t < 10 && txs[0]; t++) tick();
        checkOutput("b2b_first_start", 0, txs[0], 1'b0);
        for (int off = 1; off <= 80; off++) begin
            tick();
            if ((off >= 36 && off <= 39) || (off >= 76 && off <= 79))
                checkOutput("b2b_stop", 0, txs[0], 1'b1);
            if (off == 40 || off == 80)
                checkOutput("b2b_next_start", 0, txs[0], 1'b0);
        end
        waitIdle(0, 200, "b2b_drain");

        // Overflow: six consecutive pushes, the sixth is dropped.
        falls = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) checkOutput("ovf_ready_high", 0, rdy[0], 1'b1);
            if (k == 5) checkOutput("ovf_ready_low", 0, rdy[0], 1'b0);
            load[0] = 1'b1;
            data[0] = 9'h0FF;
            tickCount(0);
        end
        load[0] = 1'b0;
        checkOutput("ovf_pulse", 0, ovf[0], 1'b1);
        tickCount(0);
        checkOutput("ovf_pulse_end", 0, ovf[0], 1'b0);
        for (int t = 0; t < 500 && !idl[0]; t++) tickCount(0);
        checkOutput("ovf_drain", 0, idl[0], 1'b1);
        checkOutput("ovf_frames", 0, falls, 5);

        // Reset in the middle of the data bits, with a second word queued.
        applyStimulus(0, 9'h000);
        applyStimulus(0, 9'h000);
        repeat (16) tick();
        checkOutput("rst_pre_low", 0, txs[0], 1'b0);
        #1 nrst[0] = 1'b0;
        #1;
        checkOutput("rst_tx_high", 0, txs[0], 1'b1);
        checkOutput("rst_ready", 0, rdy[0], 1'b1);
        checkOutput("rst_idle", 0, idl[0], 1'b1);
        tick();
        nrst[0] = 1'b1;
        lows = 0;
        repeat (100) begin
            tick();
            if (!txs[0]) lows++;
        end
        checkOutput("rst_no_frames", 0, lows, 0);
        checkOutput("rst_still_idle", 0, idl[0], 1'b1);

        // Randomised traffic with varying density and occasional one-cycle resets.
        density = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) density = $urandom_range(2, 90);
            for (int i = 0; i < NI; i++) begin
                load[i] = ($urandom_range(0, 99) < density);
                data[i] = 9'($urandom);
                nrst[i] = !($urandom_range(0, 799) == 0);
            end
            tick();
        end
        load = '0;
        nrst = '1;
        for (int i = 0; i < NI; i++) waitIdle(i, 1000, "rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with a small input FIFO, successor to the fixed 8N1 transmitter in the console path. It serialises words pushed by the CPU I/O bus logic onto a single `tx` line. The data width, parity mode, stop-bit count, baud divider and FIFO depth are all set by parameters. Back-to-back frames are sent with no idle gap while the FIFO holds data.

## Interface
- `CLOCK_RATE`, 50_000_000: input clock frequency in Hz.
- `BAUD`, 115_200: line rate in bit/s. `DIVIDER = CLOCK_RATE / BAUD`, using integer division. `DIVIDER` must be at least 2; this is checked at elaboration.
- `DATA_BITS`, 8: data bits per frame. Legal range is 5 to 9.
- `PARITY`, 0: 0 selects no parity, 1 selects odd, 2 selects even.
- `STOP_BITS`, 1: legal values are 1 or 2.
- `FIFO_DEPTH`, 4: number of FIFO entries. Must be a power of 2 and at least 2.
- Ports:
  - `clk`, input, 1: the single clock. All logic is rising-edge.
  - `nrst`, input, 1: asynchronous, active-low reset.
  - `tx_load`, input, 1: push `tx_data` into the FIFO this cycle.
  - `tx_data`, input, `DATA_BITS`: word to transmit. Bit 0 is sent first.
  - `tx_ready`, output, 1: high when the FIFO is not full.
  - `tx_idle`, output, 1: high when the FIFO is empty and no frame is in progress.
  - `tx_overflow`, output, 1: one-cycle pulse when a push is dropped.
  - `tx`, output, 1: serial line. Registered. Idles high.

## Operation
- **FIFO**
  - Write pointer, read pointer and an occupancy count. Pointers wrap modulo `FIFO_DEPTH`.
  - `tx_ready = (count != FIFO_DEPTH)`.
  - A push while full is dropped and `tx_overflow` pulses. This holds even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave `count` unchanged.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE, FIFO non-empty: pop the head into the shift register and enter START.
  - START: `tx = 0` for one bit period, then go to DATA.
  - DATA: send `DATA_BITS` bits, LSB first, one bit period each. The bit index counts 0 to `DATA_BITS-1`. Next state is PAR if `PARITY != 0`, otherwise STOP.
  - PAR: send one parity bit.
    - Even parity: XOR of all data bits.
    - Odd parity: inverse of that XOR.
  - STOP: `tx = 1` for `STOP_BITS` bit periods. At the end of STOP:
    - FIFO non-empty: pop and go directly to START. No extra high cycle is inserted.
    - FIFO empty: go to IDLE.
- **Bit timer**
  - Reloaded with `DIVIDER-1` on every state entry and every bit boundary. It counts down to 0.
  - A bit ends in the cycle where the timer is 0, so each bit lasts exactly `DIVIDER` cycles.
  - Width is `$clog2(DIVIDER)` bits.
- **Frame length:** `DIVIDER × (1 + DATA_BITS + (PARITY != 0) + STOP_BITS)` cycles.
- **Register widths:** the stop-bit counter and the bit index are sized to hold their maximum value without overflow.
- **Output:** `tx` is driven from a register, not decoded combinationally from the state.
- **Invalid input:** `PARITY = 3` is an elaboration error.

## Timing
- **Reset values (asynchronous):**
  - `tx = 1`, `tx_ready = 1`, `tx_idle = 1`, `tx_overflow = 0`.
  - FIFO empty, FSM in IDLE, bit timer at 0.
- **Latency:** with the block idle, `tx_load` sampled at edge N gives `tx = 0` after edge N+2. The FIFO write happens at N and the pop/START entry at N+1.
- **Ready update:** `tx_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- **Idle flag:** `tx_idle` falls after edge N+1 for a push at edge N. It rises in the first cycle after the final STOP bit ends with the FIFO empty.
- **Reset mid-frame:** `tx` returns to 1 immediately. The FIFO contents are discarded.
- **Mid-frame data:** a push during a frame never disturbs the frame in progress.
- **Synchronisation:** `nrst` deassertion is synchronised externally. The block assumes `nrst` is release-synchronous.

## Test plan
Parameters: `CLOCK_RATE = 40`, `BAUD = 10`, so `DIVIDER = 4`.

- **8N1:** push 0x55 from idle → `tx` is 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. Total 40 cycles. `tx_idle` returns high in cycle 43 after the push.
- **8E2 / 8O1:** push 0xA3 with even parity → parity bit is 0, followed by 8 stop cycles. Same push with odd parity → parity bit is 1, frame is 44 cycles.
- **7-bit:** `DATA_BITS = 7`, push 0x7F → seven 1 bits after start, then stop. Frame is 36 cycles.
- **Back-to-back:** push 0x01, 0x02, 0x03 on consecutive cycles → three frames with no high cycles beyond the stop bits. The start bit of frame 2 begins exactly 40 cycles after the start of frame 1.
- **Overflow:** with `FIFO_DEPTH = 4` and idle, push 6 words on consecutive cycles.
  - First word is popped at once, so words 1–5 fit (1 in flight plus 4 queued).
  - The 6th push sees `tx_ready = 0` and gives a one-cycle `tx_overflow` pulse.
  - Exactly 5 frames are sent.
- **Reset mid-frame:** assert `nrst` low for 1 cycle in the middle of the data bits → `tx` goes to 1 asynchronously and stays high. `tx_ready` and `tx_idle` are 1. No further frames are sent.
